truthtable_sweeper: RTL and testbench
=====================================

Name: truthtable_sweeper

Overview:
Sequential controller that exhaustively exercises a NIN-input, 1-output combinational truth-table block. It drives every input combination in ascending order and holds each one for SETTLE cycles. It captures the block's output into a 2^NIN-bit table and compares the table against an expected vector. It replaces the open-loop testbench loop with a synthesizable self-check sequencer that sits beside the combinational function.

Parameters:
NIN, 3, number of inputs of the swept function; table width is 2^NIN.
SETTLE, 1, clock cycles each input vector is held before x_in is captured; must be >= 1.

Ports:
clk  input  1  system clock, rising-edge active.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request a sweep; sampled only in IDLE.
expected  input  2^NIN  golden table; bit i is the expected x for input vector i.
abc_out  output  NIN  input vector driven to the function; MSB = a, LSB = c for NIN=3.
x_in  input  1  function output, sampled on the capture edge.
busy  output  1  high while a sweep is in progress.
done  output  1  one-cycle completion pulse.
table_out  output  2^NIN  captured table; bit i = x_in observed for vector i.
mismatch  output  2^NIN  bit i = table_out[i] XOR expected[i].
pass  output  1  high when the completed sweep had no mismatch.

Behaviour:
- One clock and one reset: clk, with rst_n asynchronous and active-low. Every register clears immediately when rst_n goes low, independent of clk.
- Reset values: abc_out=0, busy=0, done=0, table_out=0, mismatch=0, pass=0. FSM=IDLE, idx=0, settle counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - done=0 and busy=0.
  - If start=1 at edge E0: latch expected into exp_reg, clear table_out, mismatch and pass, set idx=0, abc_out=0, counter=0, busy=1, and go to RUN.
  - If start=0, all results hold.
- RUN:
  - abc_out = idx, stable for exactly SETTLE cycles; the counter increments each edge.
  - On the edge where counter==SETTLE-1 (the capture edge):
    - table_out[idx] <= x_in.
    - mismatch[idx] <= x_in ^ exp_reg[idx].
    - counter <= 0.
  - After a capture, if idx < 2^NIN-1: idx and abc_out increment, and the FSM stays in RUN.
  - After a capture at idx == 2^NIN-1:
    - go to DONE and set done=1, busy=0.
    - pass <= (final mismatch vector including this bit == 0).
    - abc_out holds the last value.
- DONE: lasts exactly one cycle, then goes to IDLE with done <= 0. start is ignored in DONE.
- Latency:
  - The capture of vector i occurs at edge E0+(i+1)*SETTLE.
  - done is high during the cycle after edge E0+2^NIN*SETTLE.
  - A new sweep can be accepted at the earliest at edge E0+2^NIN*SETTLE+2.
- start while busy, or held high continuously: ignored until IDLE. A continuously high start restarts the sweep in the first IDLE cycle.
- expected is used only when latched at E0; changes during a sweep have no effect.
- Counters wrap neither way: idx saturates at the last vector, and the FSM leaves RUN at that point.
- table_out, mismatch and pass hold after DONE until the next accepted start or reset.
- Partial results stay visible during RUN: bits not yet captured read 0.
- Reset mid-sweep: immediate return to reset values. No sweep occurs after release without a new start.

Test Plan:
1. NIN=3, SETTLE=1, connect x = ~a&b | ~c&~a | ~c&b | a&~b&c, expected=8'h6D, 1-cycle start pulse -> abc_out steps 0..7 one per cycle; done high in the cycle after edge E0+8; table_out=8'h6D, mismatch=8'h00, pass=1.
2. Same function, expected=8'h6F -> table_out=8'h6D, mismatch=8'h02, pass=0, done pulse one cycle wide.
3. SETTLE=3, same function, expected=8'h6D -> each abc_out value held 3 cycles; done after edge E0+24; pass=1.
4. start held high throughout, plus extra start pulses while busy -> no restart during RUN or DONE; a second sweep begins in the first IDLE cycle; busy low for exactly the DONE and IDLE cycles between sweeps.
5. rst_n pulled low asynchronously mid-cycle while abc_out=4 -> abc_out, busy, done, table_out, mismatch and pass go to 0 without a clock edge; after release, outputs stay 0 and no sweep starts until start is asserted.
6. expected changed from 8'h6D to 8'h00 at abc_out=3 -> the result still uses 8'h6D: mismatch=8'h00, pass=1.

Source files
------------

// File: rtl/truthtable_sweeper.sv
// Exhaustive sweep sequencer for a NIN-input, 1-output combinational block.
// Drives every input vector in ascending order, captures x_in into a table,
// and compares the table against a golden vector latched at start.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      sweep request, sampled only in IDLE
//   expected   golden table, bit i = expected x for vector i
//   abc_out    input vector driven to the swept function
//   x_in       swept function output
//   busy       high while a sweep runs
//   done       one-cycle completion pulse
//   table_out  captured table, bit i = x_in seen for vector i
//   mismatch   table_out XOR latched expected
//   pass       completed sweep had no mismatch
module truthtable_sweeper #(
   parameter int NIN    = 3,
   parameter int SETTLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2**NIN-1:0] expected,
   output logic [NIN-1:0]    abc_out,
   input  logic              x_in,
   output logic              busy,
   output logic              done,
   output logic [2**NIN-1:0] table_out,
   output logic [2**NIN-1:0] mismatch,
   output logic              pass
);

   localparam int W  = 2**NIN;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [NIN-1:0] LAST = {NIN{1'b1}};
   localparam logic [CW-1:0]  CAP  = CW'(SETTLE - 1);

   logic [1:0]     state;
   logic [NIN-1:0] idx;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   exp_reg;

   logic           capture;
   logic [W-1:0]   tbl_nxt;
   logic [W-1:0]   mis_nxt;

   // Next table/mismatch values including the bit captured on this edge;
   // pass is judged from mis_nxt so the final bit is not missed.
   always_comb begin
      capture      = (state == RUN) && (cnt == CAP);
      tbl_nxt      = table_out;
      mis_nxt      = mismatch;
      tbl_nxt[idx] = x_in;
      mis_nxt[idx] = x_in ^ exp_reg[idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         cnt       <= '0;
         exp_reg   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         table_out <= '0;
         mismatch  <= '0;
         pass      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  exp_reg   <= expected;
                  table_out <= '0;
                  mismatch  <= '0;
                  pass      <= 1'b0;
                  idx       <= '0;
                  cnt       <= '0;
                  busy      <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (capture) begin
                  table_out <= tbl_nxt;
                  mismatch  <= mis_nxt;
                  cnt       <= '0;
                  if (idx == LAST) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     pass  <= (mis_nxt == '0);
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign abc_out = idx;

endmodule

// File: tb/tb_truthtable_sweeper.sv
// Bench for truthtable_sweeper: two instances (SETTLE=1 and SETTLE=3)
// checked against a cycle-count model of the sweep.
module tb_truthtable_sweeper;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       start_s [2];
   logic [7:0] exp_s   [2];
   logic [7:0] func_s  [2];
   logic [7:0] tbl_s   [2];
   logic [7:0] mis_s   [2];
   logic [2:0] abc_s   [2];
   logic       x_s     [2];
   logic       busy_s  [2];
   logic       done_s  [2];
   logic       pass_s  [2];

   int total = 0;
   int bad   = 0;

   assign x_s[0] = func_s[0][abc_s[0]];
   assign x_s[1] = func_s[1][abc_s[1]];

   truthtable_sweeper #(.NIN(3), .SETTLE(1)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]),
      .expected(exp_s[0]), .abc_out(abc_s[0]), .x_in(x_s[0]),
      .busy(busy_s[0]), .done(done_s[0]), .table_out(tbl_s[0]),
      .mismatch(mis_s[0]), .pass(pass_s[0])
   );

   truthtable_sweeper #(.NIN(3), .SETTLE(3)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]),
      .expected(exp_s[1]), .abc_out(abc_s[1]), .x_in(x_s[1]),
      .busy(busy_s[1]), .done(done_s[1]), .table_out(tbl_s[1]),
      .mismatch(mis_s[1]), .pass(pass_s[1])
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h @%0t", tag, got, want, $time);
      end
   endtask

   // x = ~a&b | ~c&~a | ~c&b | a&~b&c, with a = MSB
   function automatic logic [7:0] ref_func();
      logic [7:0] r;
      logic a, b, c;
      for (int v = 0; v < 8; v++) begin
         a = v[2]; b = v[1]; c = v[0];
         r[v] = (~a & b) | (~c & ~a) | (~c & b) | (a & ~b & c);
      end
      return r;
   endfunction

   task automatic drain(input int k);
      int c = 0;
      while (!done_s[k] && c < 200) begin
         @(negedge clk);
         c++;
      end
      chk("drain_timeout", 32'(c < 200), 32'd1);
      @(negedge clk);
   endtask

   // One sweep on instance k; model: vector t/s shown after edge E0+t,
   // t/s vectors captured so far, done after edge E0+8*s.
   task automatic sweep(input int k, input logic [7:0] fn,
                        input logic [7:0] ex, input bit hold,
                        input bit chg);
      int s = (k == 1) ? 3 : 1;
      int n = 8 * s;
      int mask;
      @(negedge clk);
      func_s[k]  = fn;
      exp_s[k]   = ex;
      start_s[k] = 1'b1;
      for (int t = 0; t < n; t++) begin
         @(negedge clk);
         if (!hold) start_s[k] = 1'b0;
         if (chg && t == 3 * s) exp_s[k] = ~ex;
         mask = (1 << (t / s)) - 1;
         chk("run_abc", 32'(abc_s[k]), 32'(t / s));
         chk("run_busy", 32'(busy_s[k]), 32'd1);
         chk("run_done", 32'(done_s[k]), 32'd0);
         chk("run_tbl", 32'(tbl_s[k]), 32'(fn & 8'(mask)));
      end
      @(negedge clk);
      chk("end_done", 32'(done_s[k]), 32'd1);
      chk("end_busy", 32'(busy_s[k]), 32'd0);
      chk("end_tbl", 32'(tbl_s[k]), 32'(fn));
      chk("end_mis", 32'(mis_s[k]), 32'(fn ^ ex));
      chk("end_pass", 32'(pass_s[k]), 32'(fn == ex));
      chk("end_abc", 32'(abc_s[k]), 32'd7);
      @(negedge clk);
      chk("idle_done", 32'(done_s[k]), 32'd0);
      chk("idle_busy", 32'(busy_s[k]), 32'd0);
      chk("hold_tbl", 32'(tbl_s[k]), 32'(fn));
      chk("hold_pass", 32'(pass_s[k]), 32'(fn == ex));
      @(negedge clk);
      if (hold) begin
         chk("restart_busy", 32'(busy_s[k]), 32'd1);
         chk("restart_abc", 32'(abc_s[k]), 32'd0);
         chk("restart_tbl", 32'(tbl_s[k]), 32'd0);
         chk("restart_pass", 32'(pass_s[k]), 32'd0);
         start_s[k] = 1'b0;
         drain(k);
      end else begin
         chk("no_restart", 32'(busy_s[k]), 32'd0);
      end
   endtask

   task automatic reset_mid;
      @(negedge clk);
      func_s[0]  = ref_func();
      exp_s[0]   = 8'h6D;
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_rst_abc", 32'(abc_s[0]), 32'd4);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_abc", 32'(abc_s[k]), 32'd0);
         chk("rst_busy", 32'(busy_s[k]), 32'd0);
         chk("rst_done", 32'(done_s[k]), 32'd0);
         chk("rst_tbl", 32'(tbl_s[k]), 32'd0);
         chk("rst_mis", 32'(mis_s[k]), 32'd0);
         chk("rst_pass", 32'(pass_s[k]), 32'd0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_busy", 32'(busy_s[0]), 32'd0);
      chk("post_rst_abc", 32'(abc_s[0]), 32'd0);
      chk("post_rst_tbl", 32'(tbl_s[0]), 32'd0);
   endtask

   initial begin
      logic [7:0] f;
      logic [7:0] fn;
      logic [7:0] ex;
      int k;
      for (int i = 0; i < 2; i++) begin
         start_s[i] = 1'b0;
         exp_s[i]   = 8'h00;
         func_s[i]  = 8'h00;
      end
      f = ref_func();
      #12;
      for (int i = 0; i < 2; i++) begin
         chk("reset_abc", 32'(abc_s[i]), 32'd0);
         chk("reset_busy", 32'(busy_s[i]), 32'd0);
         chk("reset_done", 32'(done_s[i]), 32'd0);
         chk("reset_tbl", 32'(tbl_s[i]), 32'd0);
         chk("reset_mis", 32'(mis_s[i]), 32'd0);
         chk("reset_pass", 32'(pass_s[i]), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      sweep(0, f, 8'h6D, 1'b0, 1'b0);
      sweep(0, f, 8'h6F, 1'b0, 1'b0);
      sweep(1, f, 8'h6D, 1'b0, 1'b0);
      sweep(0, f, 8'h6D, 1'b1, 1'b0);
      sweep(1, f, 8'h6D, 1'b1, 1'b0);
      reset_mid();
      sweep(0, f, 8'h6D, 1'b0, 1'b1);
      sweep(1, f, 8'h6D, 1'b0, 1'b1);

      for (int r = 0; r < 8; r++) begin
         k  = r % 2;
         fn = 8'($urandom);
         if ($urandom_range(0, 1) == 1)
            ex = fn;
         else
            ex = fn ^ 8'($urandom_range(1, 255));
         sweep(k, fn, ex, 1'b0, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
